// File: rtl/conv_pkg.sv
// Shared types and helpers for the 3x3 streaming convolution: FSM states,
// coefficient storage, the identity kernel loaded at reset and the accumulator width.
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } conv_state_e;

  // Coefficients are held sign-extended to a fixed width; COEF_W must not exceed it.
  localparam int COEF_STORE_W = 32;
  typedef logic signed [COEF_STORE_W-1:0] coef_t;
  typedef coef_t coef_arr_t [9];

  localparam coef_arr_t IDENTITY_KERNEL = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

  // Nine products of (WORD_SIZE+1)-bit by COEF_W-bit signed values never overflow this.
  function automatic int sum_width(input int word_w, input int coef_w);
    return word_w + coef_w + 5;
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// DEPTH-deep delay line: dout is the sample written DEPTH shifts ago.
// Circular storage; only the pointer is reset, the contents are not.
module conv_line_buffer #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 540
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 shift_en,
  input  logic [WORD_SIZE-1:0] din,
  output logic [WORD_SIZE-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [WORD_SIZE-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     ptr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[ptr] <= din;
    end
  end

  // Read-before-write: the slot about to be overwritten holds the oldest sample.
  assign dout = mem[ptr];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution over a raster image with a two-stage multiply/sum pipeline.
// Define CONV_ABS_EN to output the clamped magnitude instead of clamping negatives to 0.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int ROW_SIZE     = 540,
  parameter int IMAGE_HEIGHT = 360,
  parameter int COEF_W       = 8,
  parameter int SHIFT        = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WORD_SIZE-1:0]     inputPixel,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic [WORD_SIZE-1:0]     outputPixel,
  output logic                     valid,
  output logic                     frame_done,
  output conv_state_e              state_dbg
);

  localparam int COL_W  = $clog2(ROW_SIZE);
  localparam int ROW_W  = $clog2(IMAGE_HEIGHT);
  localparam int PROD_W = WORD_SIZE + COEF_W + 1;
  localparam int SUM_W  = sum_width(WORD_SIZE, COEF_W);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic signed [SUM_W-1:0] PIX_MAX =
    $signed({{(SUM_W-WORD_SIZE){1'b0}}, {WORD_SIZE{1'b1}}});

  conv_state_e state_q, state_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  logic accept, out_en, last_px;

  logic [WORD_SIZE-1:0] tap1, tap2;
  logic [WORD_SIZE-1:0] win_q [9];
  coef_arr_t            coef_q;

  logic signed [PROD_W-1:0] prod_d [9];
  logic signed [PROD_W-1:0] prod_q [9];
  logic signed [SUM_W-1:0]  sum_d, shifted, mag;
  logic [WORD_SIZE-1:0]     pix_d;

  logic win_vld, win_last, prod_vld, prod_last, out_last;

  // Handshake: in_valid has no ready; a pixel is consumed on every rising edge with
  // in_valid=1 unless the FSM is in DONE. valid/frame_done are single-cycle outputs
  // with no back-pressure.
  assign accept  = in_valid && (state_q != ST_DONE);
  assign out_en  = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
  assign last_px = accept && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign state_dbg = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_FILL;
      ST_FILL: if (accept && (row_q == ROW_W'(2)) && (col_q == '0)) state_d = ST_RUN;
      ST_RUN:  if (last_px) state_d = ST_DONE;
      ST_DONE: if (out_last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == COL_LAST) begin
        col_q <= '0;
        row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  conv_line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb0 (
    .clk(clk), .rst(rst), .shift_en(accept), .din(inputPixel), .dout(tap1)
  );

  conv_line_buffer #(.WORD_SIZE(WORD_SIZE), .DEPTH(ROW_SIZE)) u_lb1 (
    .clk(clk), .rst(rst), .shift_en(accept), .din(tap1), .dout(tap2)
  );

  // Window index is row*3+col, row 0 oldest; new column enters at col 2.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) win_q[i] <= '0;
    end else if (accept) begin
      for (int rr = 0; rr < 3; rr++) begin
        win_q[rr*3]   <= win_q[rr*3+1];
        win_q[rr*3+1] <= win_q[rr*3+2];
      end
      win_q[2] <= tap2;
      win_q[5] <= tap1;
      win_q[8] <= inputPixel;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coef_q <= IDENTITY_KERNEL;
    end else if (coef_we && (state_q == ST_IDLE) && (coef_addr <= 4'd8)) begin
      coef_q[coef_addr] <= coef_t'(coef_data);
    end
  end

  always_comb begin
    for (int i = 0; i < 9; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, win_q[i]}) * coef_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= '0;
    end else if (win_vld) begin
      for (int i = 0; i < 9; i++) prod_q[i] <= prod_d[i];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < 9; i++) begin
      sum_d = sum_d + SUM_W'(prod_q[i]);
    end
    shifted = sum_d >>> SHIFT;
`ifdef CONV_ABS_EN
    mag = shifted[SUM_W-1] ? -shifted : shifted;
`else
    mag = shifted;
`endif
    if (mag < 0)            pix_d = '0;
    else if (mag > PIX_MAX) pix_d = '1;
    else                    pix_d = mag[WORD_SIZE-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_vld     <= 1'b0;
      win_last    <= 1'b0;
      prod_vld    <= 1'b0;
      prod_last   <= 1'b0;
      valid       <= 1'b0;
      out_last    <= 1'b0;
      frame_done  <= 1'b0;
      outputPixel <= '0;
    end else begin
      win_vld    <= out_en;
      win_last   <= last_px;
      prod_vld   <= win_vld;
      prod_last  <= win_last;
      valid      <= prod_vld;
      out_last   <= prod_last;
      frame_done <= out_last;
      if (prod_vld) outputPixel <= pix_d;
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on an 8x6 image: directed frames with random content,
// kernels and input gaps, checked against a plain-arithmetic convolution model.
module tb_conv3x3_stream;
  import conv_pkg::*;

  localparam int W     = 8;
  localparam int R     = 8;
  localparam int H     = 6;
  localparam int CW    = 8;
  localparam int SHIFT = 0;
  localparam int NOUT  = (R-2)*(H-2);

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic [W-1:0]      inputPixel = '0;
  logic              coef_we = 1'b0;
  logic [3:0]        coef_addr = '0;
  logic [CW-1:0]     coef_data = '0;
  logic [W-1:0]      outputPixel;
  logic              valid;
  logic              frame_done;
  conv_state_e       state_dbg;

  conv3x3_stream #(
    .WORD_SIZE(W), .ROW_SIZE(R), .IMAGE_HEIGHT(H), .COEF_W(CW), .SHIFT(SHIFT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .inputPixel(inputPixel),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .outputPixel(outputPixel), .valid(valid), .frame_done(frame_done),
    .state_dbg(state_dbg)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];
  logic [W-1:0] out_log[$];
  logic [W-1:0] img [H][R];
  int           kern [9];
  int out_cnt = 0;
  int fd_cnt = 0;
  int last_valid_cyc = -10;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // scoreboard: every valid output must match the next expected value and latency
  always @(negedge clk) begin
    if (rst) begin
      if (valid) begin
        check("valid_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("pixel", outputPixel, exp_q.pop_front());
        if (exp_t_q.size() != 0) check("latency", cyc, exp_t_q.pop_front() + 2);
        out_log.push_back(outputPixel);
        out_cnt++;
        last_valid_cyc = cyc;
      end
      if (frame_done) begin
        fd_cnt++;
        check("frame_done_timing", cyc, last_valid_cyc + 1);
      end
    end
  end

  // reference model: direct 3x3 sum over interior pixels in raster order
  task automatic build_expected();
    for (int r = 1; r < H-1; r++) begin
      for (int c = 1; c < R-1; c++) begin
        int s;
        s = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            s += kern[(dr+1)*3 + (dc+1)] * int'(img[r+dr][c+dc]);
        s = s >>> SHIFT;
`ifdef CONV_ABS_EN
        if (s < 0) s = -s;
`endif
        if (s < 0) s = 0;
        if (s > (1 << W) - 1) s = (1 << W) - 1;
        exp_q.push_back(W'(s));
      end
    end
  endtask

  task automatic load_kernel();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      coef_we = 1'b1;
      coef_addr = 4'(i);
      coef_data = CW'(kern[i]);
    end
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic fill_image(input int mode, input int value);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < R; c++)
        img[r][c] = (mode == 0) ? W'(value) : W'($urandom_range(0, 255));
  endtask

  // gap_mode: 0 none, 1 alternate idle cycles, 2 random idle cycles
  task automatic drive_frame(input int gap_mode, input int poke_idx, input int abort_idx);
    for (int p = 0; p < R*H; p++) begin
      int r;
      int c;
      r = p / R;
      c = p % R;
      if (gap_mode == 2) begin
        while ($urandom_range(0, 2) == 0) begin
          @(negedge clk);
          in_valid = 1'b0;
          coef_we = 1'b0;
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      inputPixel = img[r][c];
      coef_we = 1'b0;
      if (p == poke_idx) begin
        check("state_run", state_dbg, ST_RUN);
        coef_we = 1'b1;
        coef_addr = 4'($urandom_range(0, 8));
        coef_data = CW'($urandom_range(20, 100));
      end
      if (r >= 2 && c >= 2) exp_t_q.push_back(cyc + 1);
      if (gap_mode == 1) begin
        @(negedge clk);
        in_valid = 1'b0;
        coef_we = 1'b0;
      end
      if (p == abort_idx) begin
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort_valid", valid, 0);
        check("abort_state", state_dbg, ST_IDLE);
        in_valid = 1'b0;
        coef_we = 1'b0;
        exp_q.delete();
        exp_t_q.delete();
        return;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    coef_we = 1'b0;
  endtask

  task automatic wait_frame(input int fd_before, input int out_before);
    int n;
    n = 0;
    while (fd_cnt == fd_before && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("frame_done_seen", fd_cnt - fd_before, 1);
    repeat (4) @(negedge clk);
    check("frame_done_once", fd_cnt - fd_before, 1);
    check("out_count", out_cnt - out_before, NOUT);
    check("exp_q_empty", exp_q.size(), 0);
    check("idle_after_frame", state_dbg, ST_IDLE);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    coef_we = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_pixel", outputPixel, 0);
    check("rst_valid", valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b1;
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
  endtask

  initial begin
    int fb;
    int ob;

    // reset state
    apply_reset();

    // all-ones kernel on a flat image of 10s
    kern = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
    load_kernel();
    fill_image(0, 10);
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(0, -1, -1);
    wait_frame(fb, ob);
    check("ones_value_first", out_log[ob], 90);
    check("ones_value_last", out_log[ob + NOUT - 1], 90);

    // same frame with in_valid toggling every cycle
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(1, -1, -1);
    wait_frame(fb, ob);

    // identity kernel after reset, random image, random gaps
    apply_reset();
    fill_image(1, 0);
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(2, -1, -1);
    wait_frame(fb, ob);
    check("identity_first", out_log[ob], img[1][1]);
    check("identity_last", out_log[ob + NOUT - 1], img[H-2][R-2]);

    // Laplacian on one bright pixel
    kern = '{0, 1, 0, 1, -4, 1, 0, 1, 0};
    load_kernel();
    fill_image(0, 0);
    img[2][3] = 8'd200;
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(0, -1, -1);
    wait_frame(fb, ob);
`ifdef CONV_ABS_EN
    check("laplace_center", out_log[ob + 8], 255);
`else
    check("laplace_center", out_log[ob + 8], 0);
`endif
    check("laplace_neighbour", out_log[ob + 7], 200);

    // random signed kernel, coefficient write attempted during RUN
    for (int i = 0; i < 9; i++) kern[i] = $urandom_range(0, 8) - 4;
    load_kernel();
    fill_image(1, 0);
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(2, 3*R + 1, -1);
    wait_frame(fb, ob);

    // out-of-range coefficient addresses in IDLE
    @(negedge clk);
    coef_we = 1'b1;
    coef_addr = 4'd9;
    coef_data = CW'($urandom_range(50, 100));
    @(negedge clk);
    coef_addr = 4'd15;
    coef_data = CW'($urandom_range(50, 100));
    @(negedge clk);
    coef_we = 1'b0;
    fill_image(1, 0);
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(0, -1, -1);
    wait_frame(fb, ob);

    // reset in the middle of row 3, then a full clean frame
    fill_image(1, 0);
    build_expected();
    drive_frame(0, -1, 3*R + 4);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    kern = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
    fill_image(1, 0);
    build_expected();
    fb = fd_cnt; ob = out_cnt;
    drive_frame(0, -1, -1);
    wait_frame(fb, ob);
    check("abort_recover_first", out_log[ob], img[1][1]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv3x3_stream.md
CONV3X3_STREAM -- requirements
Module: conv3x3_stream

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, pixel width in bits (unsigned).
REQ-002 SHALL have parameter ROW_SIZE, default 540, image width in pixels (>=3).
REQ-003 SHALL have parameter IMAGE_HEIGHT, default 360, image height in rows (>=3).
REQ-004 SHALL have parameter COEF_W, default 8, signed coefficient width.
REQ-005 SHALL have parameter SHIFT, default 0, arithmetic right shift applied to the sum.
REQ-006 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port in_valid  input  1  inputPixel is valid this cycle.
REQ-009 SHALL have port inputPixel  input  WORD_SIZE  raster pixel, row-major, left to right.
REQ-010 SHALL have port coef_we  input  1  coefficient write strobe.
REQ-011 SHALL have port coef_addr  input  4  coefficient index 0..8, row-major over the 3x3 window.
REQ-012 SHALL have port coef_data  input  COEF_W  signed coefficient value.
REQ-013 SHALL have port outputPixel  output  WORD_SIZE  convolved pixel.
REQ-014 SHALL have port valid  output  1  outputPixel is valid this cycle.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse after the last output of a frame.

Function
REQ-016 SHALL implement FSM IDLE -> FILL on the first accepted pixel, FILL -> RUN when row 2 column 0 is accepted, RUN -> DONE when pixel (IMAGE_HEIGHT-1, ROW_SIZE-1) is accepted, and DONE -> IDLE once the pipeline drains.
REQ-017 SHALL accept a pixel only when in_valid=1; gaps stall the column/row counters and line buffers with no data loss.
REQ-018 SHALL hold two ROW_SIZE-deep line buffers plus a 3x3 window register; the column counter wraps ROW_SIZE-1 -> 0 and increments the row counter.
REQ-019 SHALL produce outputs only for interior pixels, i.e. when accepting pixel (r,c) with r>=2 and c>=2, giving (ROW_SIZE-2)*(IMAGE_HEIGHT-2) outputs per frame.
REQ-020 SHALL assert valid exactly 2 cycles after the accepting edge: stage 1 registers the nine products, stage 2 registers the sum, shift and clamp.
REQ-021 SHALL compute each product as the zero-extended pixel times the signed coefficient, and SHALL sum the products at full width WORD_SIZE+COEF_W+5 with no overflow.
REQ-022 SHALL form the result as (sum >>> SHIFT) clamped to [0, 2^WORD_SIZE-1].
REQ-023 SHALL accept coef_we only in IDLE and only for coef_addr<=8; other writes SHALL be ignored.
REQ-024 SHALL raise frame_done for exactly one cycle, one cycle after the last valid output of the frame.
REQ-025 SHALL accept the next frame in the cycle after frame_done.

Reset
REQ-026 SHALL, while rst=0, force outputPixel=0, valid=0, frame_done=0, state=IDLE and counters=0, and SHALL cancel any in-flight pipeline data.
REQ-027 SHALL load the coefficients on reset with the identity kernel (index 4 = 1, all others 0); line buffer contents need not be cleared.
REQ-028 SHALL treat reset in the middle of a frame as an abort; the next pixel accepted after reset is pixel (0,0).

Configuration
REQ-029 SHALL, with macro CONV_ABS_EN defined, replace the shifted sum by its absolute value before the clamp, for edge magnitude.
REQ-030 SHALL, with CONV_ABS_EN not defined, clamp negative results to 0.

Structure
REQ-031 SHALL take the FSM state enum, the coefficient array typedef, the identity-kernel constant and the sum-width function from shared package conv_pkg.
REQ-032 SHALL instantiate sub-module conv_line_buffer (a ROW_SIZE-deep, WORD_SIZE-wide delay line with a shift enable) twice.

Verification
REQ-033 SHALL verify, with ROW_SIZE=8, IMAGE_HEIGHT=6, an all-ones kernel, SHIFT=0 and every pixel 10: 24 outputs each 90, frame_done pulsed once.
REQ-034 SHALL verify, for the same image with the identity kernel after reset, that the output sequence equals input interior pixels (1..4,1..6) in raster order, each valid 2 cycles after pixel (r+1,c+1) is accepted.
REQ-035 SHALL verify a Laplacian kernel (centre -4, edges 1, corners 0) on a single bright pixel 200 on zero background: output -800 gives 0 without CONV_ABS_EN and 255 with CONV_ABS_EN.
REQ-036 SHALL verify that in_valid toggling 1/0 every cycle yields the same 24 values as REQ-033, with no duplicates.
REQ-037 SHALL verify that a coefficient write in RUN is ignored (outputs unchanged) and that a write with coef_addr=9 in IDLE is ignored.
REQ-038 SHALL verify that rst=0 applied at row 3: valid=0 immediately, and a following full frame produces exactly 24 correct outputs.
